// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP                 = 32'h0000_0000;
  localparam int          DEFAULT_DEPTH       = 64;
  localparam int          DEFAULT_WAIT_CYCLES = 2;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word storage, one synchronous write port and one registered read port
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  // No reset: contents must survive i_arst
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with load port and fault check
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_arst,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          o_ready,
  output logic          o_valid,
  output logic [31:0]   o_instr,
  output logic          o_err,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [31:0]   i_ld_data
);

  localparam int WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  state_t        r_state;
  state_t        w_next_state;
  logic [3:0]    r_cnt;
  logic [3:0]    w_next_cnt;
  logic [31:0]   r_addr;
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_fault;
  logic [AW-1:0] w_raddr;
  logic [31:0]   w_rdata;

  assign w_accept = i_req && (r_state == S_IDLE);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          w_next_cnt   = 4'(WAIT_INIT);
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_addr <= i_addr;
      end
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, before r_addr holds the address
  assign w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP) && !i_arst;
  assign w_raddr      = (r_state == S_IDLE) ? i_addr[AW+1:2] : r_addr[AW+1:2];

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (i_ld_we && !i_arst),
    .i_waddr (i_ld_addr),
    .i_wdata (i_ld_data),
    .i_re    (w_enter_resp),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_fault = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_RESP);
  assign o_err   = o_valid && w_fault;
  assign o_instr = (o_valid && !w_fault) ? w_rdata : NOP;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        arst;
  logic        req;
  logic [31:0] addr;
  logic        ready, valid, err;
  logic [31:0] instr;
  logic        ld_we;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;

  logic        z_req;
  logic [31:0] z_addr;
  logic        z_ready, z_valid, z_err;
  logic [31:0] z_instr;
  logic        z_ld_we;
  logic [5:0]  z_ld_addr;
  logic [31:0] z_ld_data;

  int n_checks = 0;
  int n_errors = 0;
  logic saw;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .i_clk(clk), .i_arst(arst), .i_req(req), .i_addr(addr),
    .o_ready(ready), .o_valid(valid), .o_instr(instr), .o_err(err),
    .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  imem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_z (
    .i_clk(clk), .i_arst(arst), .i_req(z_req), .i_addr(z_addr),
    .o_ready(z_ready), .o_valid(z_valid), .o_instr(z_instr), .o_err(z_err),
    .i_ld_we(z_ld_we), .i_ld_addr(z_ld_addr), .i_ld_data(z_ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_i, input logic exp_e);
    req = 1'b1; addr = a;
    tick();
    req = 1'b0; addr = 32'd0;
    tick();
    tick();
    chk1({tag, "_valid"}, valid, 1'b1);
    chk32({tag, "_instr"}, instr, exp_i);
    chk1({tag, "_err"}, err, exp_e);
    tick();
    chk1({tag, "_done"}, valid, 1'b0);
  endtask

  initial begin
    arst = 1'b1; req = 1'b0; addr = 32'd0; ld_we = 1'b0; ld_addr = 6'd0; ld_data = 32'd0;
    z_req = 1'b0; z_addr = 32'd0; z_ld_we = 1'b0; z_ld_addr = 6'd0; z_ld_data = 32'd0;
    #2;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_valid", valid, 1'b0);
    chk32("rst_instr", instr, 32'h0);
    chk1("rst_err", err, 1'b0);
    tick(); tick();
    arst = 1'b0;

    load(6'd3, 32'h2008_0005);
    load(6'd63, 32'h1234_5678);
    load(6'd4, 32'hDEAD_BEEF);

    // basic fetch with cycle-by-cycle timing
    req = 1'b1; addr = 32'h0000_000C;
    chk1("b_ready_n", ready, 1'b1);
    tick();
    req = 1'b0; addr = 32'd0;
    chk1("b_ready_n1", ready, 1'b0);
    chk1("b_valid_n1", valid, 1'b0);
    tick();
    chk1("b_ready_n2", ready, 1'b0);
    chk1("b_valid_n2", valid, 1'b0);
    tick();
    chk1("b_valid_n3", valid, 1'b1);
    chk32("b_instr_n3", instr, 32'h2008_0005);
    chk1("b_err_n3", err, 1'b0);
    chk1("b_ready_n3", ready, 1'b0);
    tick();
    chk1("b_valid_n4", valid, 1'b0);
    chk1("b_ready_n4", ready, 1'b1);
    chk32("b_instr_n4", instr, 32'h0);

    fetch("misalign", 32'h0000_0006, 32'h0, 1'b1);
    fetch("range", 32'h0000_0100, 32'h0, 1'b1);
    fetch("lastword", 32'h0000_00FC, 32'h1234_5678, 1'b0);

    // request held during WAIT is ignored until next IDLE
    req = 1'b1; addr = 32'h0000_000C;
    tick();
    addr = 32'h0000_0010;
    chk1("h_valid_n1", valid, 1'b0);
    tick();
    chk1("h_valid_n2", valid, 1'b0);
    tick();
    chk1("h_valid_n3", valid, 1'b1);
    chk32("h_instr_n3", instr, 32'h2008_0005);
    chk1("h_ready_n3", ready, 1'b0);
    tick();
    chk1("h_valid_n4", valid, 1'b0);
    chk1("h_ready_n4", ready, 1'b1);
    tick();
    req = 1'b0; addr = 32'd0;
    chk1("h_ready_n5", ready, 1'b0);
    chk1("h_valid_n5", valid, 1'b0);
    tick();
    chk1("h_valid_n6", valid, 1'b0);
    tick();
    chk1("h_valid_n7", valid, 1'b1);
    chk32("h_instr_n7", instr, 32'hDEAD_BEEF);
    tick();

    // write in WAIT cycle 1 is visible
    load(6'd3, 32'h1111_1111);
    req = 1'b1; addr = 32'h0000_000C;
    tick();
    req = 1'b0;
    ld_we = 1'b1; ld_addr = 6'd3; ld_data = 32'h2222_2222;
    tick();
    ld_we = 1'b0;
    tick();
    chk32("wr_wait_instr", instr, 32'h2222_2222);
    tick();

    // write on the RESP-entry edge is not visible
    load(6'd3, 32'h1111_1111);
    req = 1'b1; addr = 32'h0000_000C;
    tick();
    req = 1'b0;
    tick();
    ld_we = 1'b1; ld_addr = 6'd3; ld_data = 32'h2222_2222;
    tick();
    ld_we = 1'b0;
    chk1("wr_resp_valid", valid, 1'b1);
    chk32("wr_resp_instr", instr, 32'h1111_1111);
    tick();

    // reset in WAIT aborts the request and suppresses load writes
    req = 1'b1; addr = 32'h0000_000C;
    tick();
    req = 1'b0; addr = 32'd0;
    ld_we = 1'b1; ld_addr = 6'd3; ld_data = 32'hBAD0_BAD0;
    arst = 1'b1;
    #1;
    chk1("ar_ready_async", ready, 1'b1);
    chk1("ar_valid_async", valid, 1'b0);
    tick();
    arst = 1'b0; ld_we = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      if (valid !== 1'b0) saw = 1'b1;
      tick();
    end
    chk1("ar_no_valid", saw, 1'b0);
    chk1("ar_ready", ready, 1'b1);
    fetch("ar_mem", 32'h0000_000C, 32'h2222_2222, 1'b0);

    // zero wait states
    z_ld_we = 1'b1; z_ld_addr = 6'd5; z_ld_data = 32'h0000_0055;
    tick();
    z_ld_we = 1'b0;
    z_req = 1'b1; z_addr = 32'h0000_0014;
    tick();
    chk1("z_valid_n1", z_valid, 1'b1);
    chk32("z_instr_n1", z_instr, 32'h0000_0055);
    chk1("z_ready_n1", z_ready, 1'b0);
    tick();
    chk1("z_valid_n2", z_valid, 1'b0);
    chk1("z_ready_n2", z_ready, 1'b1);
    tick();
    z_req = 1'b0;
    chk1("z_valid_n3", z_valid, 1'b1);
    chk32("z_instr_n3", z_instr, 32'h0000_0055);
    chk1("z_err_n3", z_err, 1'b0);
    tick();
    chk1("z_valid_n4", z_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 64, memory size in 32-bit words (power of two, 4..256).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 i_clk  input  1  clock, rising-edge active.
REQ-004 i_arst  input  1  reset, asynchronous, active-high.
REQ-005 i_req  input  1  fetch request from the program counter side.
REQ-006 i_addr  input  32  byte address of the requested instruction.
REQ-007 o_ready  output  1  responder idle; request accepted when i_req and o_ready are both high at a rising edge.
REQ-008 o_valid  output  1  response strobe, one cycle wide.
REQ-009 o_instr  output  32  instruction word; qualified by o_valid.
REQ-010 o_err  output  1  access fault; qualified by o_valid.
REQ-011 i_ld_we  input  1  load-port write enable for boot/program load.
REQ-012 i_ld_addr  input  log2(DEPTH)  load-port word address.
REQ-013 i_ld_data  input  32  load-port write data.

Function
REQ-014 FSM states IDLE, WAIT, RESP; o_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on accept, latch i_addr; go to WAIT with wait counter = WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES = 0.
REQ-016 WAIT: decrement counter each cycle; go to RESP the cycle after the counter reads 0.
REQ-017 Accept-to-o_valid latency SHALL be exactly WAIT_CYCLES+1 cycles (accept edge N -> o_valid high during cycle N+WAIT_CYCLES+1).
REQ-018 RESP: o_valid = 1 for exactly one cycle, then unconditionally return to IDLE; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-019 i_req and i_addr SHALL be ignored outside IDLE; only the address latched at accept is served.
REQ-020 Fault, evaluated on the latched address: addr[1:0] != 0 (misaligned) or addr[31:2] >= DEPTH (out of range).
REQ-021 On fault: o_err = 1, o_instr = 32'h0000_0000 (NOP); otherwise o_err = 0, o_instr = mem[addr[31:2]].
REQ-022 o_instr and o_err SHALL be 0 whenever o_valid = 0.
REQ-023 Memory read SHALL sample contents on the edge entering RESP; a load write on that same edge is not visible, and a write on any earlier edge after accept is visible.
REQ-024 Load writes SHALL commit on any rising edge with i_ld_we = 1, in every FSM state, without affecting FSM timing.
REQ-025 Memory contents SHALL not be cleared by reset.

Reset
REQ-026 i_arst SHALL force IDLE, counter 0, o_valid = 0, o_err = 0, o_instr = 0, o_ready = 1 immediately, independent of i_clk.
REQ-027 Reset during WAIT or RESP SHALL abort the pending request; no o_valid SHALL be issued for it after release.
REQ-028 Load writes SHALL be suppressed while i_arst is high.

Structure
REQ-029 Shared package imem_pkg SHALL hold the FSM state typedef, the NOP constant 32'h0000_0000 and the default DEPTH/WAIT_CYCLES values.
REQ-030 Storage SHALL be one sub-module imem_array (one synchronous write port, one read port); FSM, counter and fault check stay in imem_responder.

Verification (DEPTH=64, WAIT_CYCLES=2 unless stated)
REQ-031 Load mem[3]=32'h2008_0005; request i_addr=32'h0000_000C at edge N -> o_valid high during cycle N+3 only, o_instr=32'h2008_0005, o_err=0; o_ready low for cycles N+1..N+3.
REQ-032 i_addr=32'h0000_0006 -> o_err=1, o_instr=0; i_addr=32'h0000_0100 (word 64) -> o_err=1, o_instr=0.
REQ-033 Accept 0x0C, then hold i_req with i_addr=0x10 during WAIT -> exactly one response (for 0x0C); 0x10 accepted only in the next IDLE cycle.
REQ-034 Load mem[3]=A before accept, then write mem[3]=B in WAIT cycle 1 -> response B; repeat with write on the RESP-entry edge -> response A.
REQ-035 Assert i_arst in WAIT cycle 1 for one cycle -> o_valid never asserts for that request; o_ready=1 after release; mem[3] unchanged.
REQ-036 WAIT_CYCLES=0: accept at edge N -> o_valid during cycle N+1; next accept possible at edge N+2.
